adf_csa_mac: RTL and testbench

- Parametrised bit-serial shift-add multiply-accumulate unit for the adaptive filter datapath.
- Multiplies one sample x by one tap weight w, one bit of x per clock.
- Partial products are kept in carry-save sum/carry registers; a single carry-propagate resolve happens at the end.
- Optionally accumulates onto the previous result, so a controller can walk the taps with one instance.

---
 rtl/adf_csa_mac.sv | 163 ++++++++++++++++
 tb/tb_adf_csa_mac.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/adf_csa_mac.sv
// Bit-serial shift-add multiply-accumulate with carry-save partial products.
// Define ADF_SIGNED_MAC_EN for two's-complement operands and signed overflow.
module adf_csa_mac #(
  parameter int unsigned XW = 8,
  parameter int unsigned WW = 10,
  parameter int unsigned AW = 20
) (
  input  logic          clk,
  input  logic          r,
  input  logic          start,
  input  logic          acc_en,
  input  logic [XW-1:0] x,
  input  logic [WW-1:0] w,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] y,
  output logic          ovf
);

  localparam int unsigned CW = (XW > 1) ? $clog2(XW) : 1;
  localparam int unsigned SW = AW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StMult,
    StResolve
  } state_e;

  state_e        r_state, w_state_nxt;
  logic [XW-1:0] r_x, w_x_nxt;
  logic [WW-1:0] r_w, w_w_nxt;
  logic [SW-1:0] r_sum, w_sum_nxt;
  logic [SW-1:0] r_carry, w_carry_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_y, w_y_nxt;
  logic          r_ovf, w_ovf_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;

  logic [SW-1:0] w_ext_w;
  logic [SW-1:0] w_ext_y;
  logic [SW-1:0] w_pp;
  logic [SW-1:0] w_addend;
  logic [SW-1:0] w_csa_sum;
  logic [SW-1:0] w_csa_carry;
  logic [AW-1:0] w_maj;
  logic [SW-1:0] w_full;
  logic          w_ovf_res;
  logic          w_last;

  assign w_last = (r_cnt == CW'(XW - 1));

  // Datapath: operand extension, one 3:2 compressor row, final resolve adder.
  always_comb begin
`ifdef ADF_SIGNED_MAC_EN
    w_ext_w = {{(SW - WW){r_w[WW-1]}}, r_w};
    w_ext_y = {r_y[AW-1], r_y};
`else
    w_ext_w = {{(SW - WW){1'b0}}, r_w};
    w_ext_y = {1'b0, r_y};
`endif
    w_pp = w_ext_w << r_cnt;
`ifdef ADF_SIGNED_MAC_EN
    // Sign bit of x carries weight -2^(XW-1): add ~pp here and +1 at the carry LSB.
    w_addend = w_last ? ~w_pp : w_pp;
`else
    w_addend = w_pp;
`endif
    w_csa_sum = r_sum ^ r_carry ^ w_addend;
    w_maj     = (r_sum[AW-1:0] & r_carry[AW-1:0]) |
                (r_sum[AW-1:0] & w_addend[AW-1:0]) |
                (r_carry[AW-1:0] & w_addend[AW-1:0]);
`ifdef ADF_SIGNED_MAC_EN
    w_csa_carry = {w_maj, w_last};
`else
    w_csa_carry = {w_maj, 1'b0};
`endif
    w_full = r_sum + r_carry;
`ifdef ADF_SIGNED_MAC_EN
    w_ovf_res = w_full[AW] ^ w_full[AW-1];
`else
    w_ovf_res = w_full[AW];
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_w_nxt     = r_w;
    w_sum_nxt   = r_sum;
    w_carry_nxt = r_carry;
    w_cnt_nxt   = r_cnt;
    w_y_nxt     = r_y;
    w_ovf_nxt   = r_ovf;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_x_nxt     = x;
          w_w_nxt     = w;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_sum_nxt   = acc_en ? w_ext_y : '0;
          w_carry_nxt = '0;
          w_state_nxt = StMult;
        end
      end
      StMult: begin
        if (r_x[r_cnt]) begin
          w_sum_nxt   = w_csa_sum;
          w_carry_nxt = w_csa_carry;
        end
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_last) begin
          w_state_nxt = StResolve;
        end
      end
      StResolve: begin
        w_y_nxt     = w_full[AW-1:0];
        w_ovf_nxt   = w_ovf_res;
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_state <= StIdle;
      r_x     <= '0;
      r_w     <= '0;
      r_sum   <= '0;
      r_carry <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_w     <= w_w_nxt;
      r_sum   <= w_sum_nxt;
      r_carry <= w_carry_nxt;
      r_cnt   <= w_cnt_nxt;
      r_y     <= w_y_nxt;
      r_ovf   <= w_ovf_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign y    = r_y;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_adf_csa_mac.sv
// Randomized self-checking bench for adf_csa_mac against an arithmetic reference model.
module tb_adf_csa_mac;

  localparam int unsigned XW = 8;
  localparam int unsigned WW = 10;
  localparam int unsigned AW = 20;

  logic          clk;
  logic          r;
  logic          start;
  logic          acc_en;
  logic [XW-1:0] x;
  logic [WW-1:0] w;
  logic          busy;
  logic          done;
  logic [AW-1:0] y;
  logic          ovf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] y_m;
  logic          ovf_m;

  adf_csa_mac #(
    .XW(XW),
    .WW(WW),
    .AW(AW)
  ) u_dut (
    .clk   (clk),
    .r     (r),
    .start (start),
    .acc_en(acc_en),
    .x     (x),
    .w     (w),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: whole-number product plus optional accumulator, then reduce to AW bits.
  task automatic model(input logic [XW-1:0] xi, input logic [WW-1:0] wi, input logic acc,
                       output logic [AW-1:0] ey, output logic eo);
    longint prod;
    longint base;
    longint full;
    longint lim;
`ifdef ADF_SIGNED_MAC_EN
    logic signed [XW-1:0] xs;
    logic signed [WW-1:0] ws;
    logic signed [AW-1:0] ys;
    xs   = xi;
    ws   = wi;
    ys   = y_m;
    prod = longint'(xs) * longint'(ws);
    base = acc ? longint'(ys) : 64'sd0;
    full = base + prod;
    lim  = longint'(1) << (AW - 1);
    eo   = (full >= lim) || (full < -lim);
`else
    prod = longint'(xi) * longint'(wi);
    base = acc ? longint'(y_m) : 64'sd0;
    full = base + prod;
    lim  = longint'(1) << AW;
    eo   = (full >= lim);
`endif
    ey    = full[AW-1:0];
    y_m   = ey;
    ovf_m = eo;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge on which done is expected.
  task automatic run_op(input logic [XW-1:0] xi, input logic [WW-1:0] wi, input logic acc,
                        input bit poke);
    logic [AW-1:0] ey;
    logic          eo;
    bit            ok_busy;
    model(xi, wi, acc, ey, eo);
    x      = xi;
    w      = wi;
    acc_en = acc;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    x      = XW'($urandom);
    w      = WW'($urandom);
    acc_en = 1'($urandom);
    check("accept_busy", busy, 1);
    check("done_one_cycle", done, 0);
    ok_busy = 1'b1;
    for (int k = 1; k <= XW + 1; k++) begin
      if (poke && k == 3) begin
        start  = 1'b1;
        x      = XW'(1);
        w      = WW'(1);
        acc_en = 1'($urandom);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (k <= XW && (busy !== 1'b1 || done !== 1'b0)) ok_busy = 1'b0;
    end
    check("busy_window", ok_busy, 1);
    check("done_pulse", done, 1);
    check("busy_low", busy, 0);
    check("y", y, ey);
    check("ovf", ovf, eo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    r      = 1'b0;
    start  = 1'b0;
    acc_en = 1'b0;
    x      = '0;
    w      = '0;
    y_m    = '0;
    ovf_m  = 1'b0;
    #1;
    check("reset_async", {y, ovf, busy, done}, '0);
    idle(2);
    check("reset_held", {y, ovf, busy, done}, '0);
    r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("idle_after_reset", {y, ovf, busy, done}, '0);
    end

    run_op(XW'(7), WW'(5), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) run_op(XW'(255), WW'(1023), 1'b1, (i == 2));

    // Abort mid-multiply: outputs clear without an edge, no done follows.
    idle(1);
    x      = XW'(7);
    w      = WW'(5);
    acc_en = 1'b0;
    start  = 1'b1;
    idle(1);
    start = 1'b0;
    idle(4);
    #3;
    r = 1'b0;
    #1;
    check("abort_async", {y, ovf, busy, done}, '0);
    y_m   = '0;
    ovf_m = 1'b0;
    begin
      bit saw_done;
      saw_done = 1'b0;
      for (int i = 0; i < 2; i++) begin
        @(posedge clk);
        #1;
        if (done !== 1'b0) saw_done = 1'b1;
      end
      r = 1'b1;
      for (int i = 0; i < XW + 2; i++) begin
        @(posedge clk);
        #1;
        if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
      end
      check("abort_no_done", saw_done, 0);
    end
    run_op(XW'(3), WW'(3), 1'b1, 1'b0);

`ifdef ADF_SIGNED_MAC_EN
    run_op(XW'(8'hFD), WW'(5), 1'b0, 1'b0);
    run_op(XW'(8'h80), WW'(10'h200), 1'b0, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [XW-1:0] rx;
      logic [WW-1:0] rw;
      rx = XW'($urandom);
      rw = WW'($urandom);
      if ($urandom_range(0, 3) == 0) rx = '1;
      if ($urandom_range(0, 3) == 0) rw = '1;
      run_op(rx, rw, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
